// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer.
// A bubble (out_valid=0) always presents all-zero control so downstream write enables stay off.
module pipe_stage_reg #(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 16,
    parameter int SKID_EN  = 1,
    parameter int CLR_DATA = 0
) (
    input  logic              i_clk,
    input  logic              i_aclr,
    input  logic              i_sclr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occ
);

    logic [1:0]        r_occ;
    logic              r_rdy;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic       w_out_valid;
    logic       w_in_ready;
    logic       w_acc;
    logic       w_drn;
    logic [1:0] w_occ_nxt;

    assign w_out_valid = (r_occ != 2'd0);

    // r_rdy is low from reset until the first edge after release; in skid mode it
    // also carries the registered "not full" flag.
    assign w_in_ready = (SKID_EN != 0) ? r_rdy : (r_rdy && (!w_out_valid || i_out_ready));

    assign w_acc = i_in_valid && w_in_ready && !i_sclr;
    assign w_drn = w_out_valid && i_out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        if (i_sclr)
            w_occ_nxt = 2'd0;
        else if (w_acc && !w_drn)
            w_occ_nxt = r_occ + 2'd1;
        else if (!w_acc && w_drn)
            w_occ_nxt = r_occ - 2'd1;
    end

    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_occ       <= 2'd0;
            r_rdy       <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            r_rdy <= (SKID_EN != 0) ? (w_occ_nxt != 2'd2) : 1'b1;
            if (i_sclr) begin
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
                if (CLR_DATA != 0)
                    r_main_data <= '0;
            end else begin
                case (r_occ)
                    2'd0: if (w_acc) begin
                        r_main_ctrl <= i_in_ctrl;
                        r_main_data <= i_in_data;
                    end
                    2'd1: begin
                        if (w_acc && !w_drn) begin
                            r_skid_ctrl <= i_in_ctrl;
                            r_skid_data <= i_in_data;
                        end else if (w_acc && w_drn) begin
                            r_main_ctrl <= i_in_ctrl;
                            r_main_data <= i_in_data;
                        end else if (w_drn) begin
                            // drain to empty: zero control so the bubble is a NOP
                            r_main_ctrl <= '0;
                        end
                    end
                    2'd2: if (w_drn) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_skid_ctrl <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_ctrl  = r_main_ctrl;
    assign o_out_data  = r_main_data;
    assign o_occ       = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: instance 0 is SKID_EN=1/CLR_DATA=0,
// instance 1 is SKID_EN=0/CLR_DATA=1; both see the same stimulus.
module tb_pipe_stage_reg;

    typedef struct {
        logic [15:0] c;
        logic [63:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        sclr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        live = 1'b0;

    logic        ir [2];
    logic        ov [2];
    logic [15:0] oc [2];
    logic [63:0] od [2];
    logic [1:0]  occ[2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // stage accepts nothing until the first edge after reset release
    always @(posedge clk or posedge aclr) begin
        if (aclr) live <= 1'b0;
        else      live <= 1'b1;
    end

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int SK = (g == 0) ? 1 : 0;
        localparam int CD = (g == 1) ? 1 : 0;

        beat_t       q[$];
        logic [63:0] idle = '0;

        pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .SKID_EN(SK), .CLR_DATA(CD)) u_dut (
            .i_clk      (clk),
            .i_aclr     (aclr),
            .i_sclr     (sclr),
            .i_in_valid (in_valid),
            .o_in_ready (ir[g]),
            .i_in_ctrl  (in_ctrl),
            .i_in_data  (in_data),
            .o_out_valid(ov[g]),
            .i_out_ready(out_ready),
            .o_out_ctrl (oc[g]),
            .o_out_data (od[g]),
            .o_occ      (occ[g])
        );

        // monitor: the queue holds exactly the beats the stage should be holding
        always @(negedge clk) begin
            logic [63:0] cand;
            logic        exp_rdy;
            if (aclr) begin
                q.delete();
                idle = '0;
                chk("rst_in_ready", g, 64'(ir[g]), 64'd0);
                chk("rst_occ", g, 64'(occ[g]), 64'd0);
                chk("rst_out_valid", g, 64'(ov[g]), 64'd0);
            end else begin
                chk("occ", g, 64'(occ[g]), 64'(q.size()));
                chk("out_valid", g, 64'(ov[g]), 64'(q.size() != 0));
                exp_rdy = (SK != 0) ? (q.size() < 2) : (q.size() == 0 || out_ready);
                chk("in_ready", g, 64'(ir[g]), live ? 64'(exp_rdy) : 64'd0);
                if (q.size() == 0) begin
                    chk("bubble_ctrl", g, 64'(oc[g]), 64'd0);
                    chk("idle_data", g, od[g], idle);
                    cand = idle;
                end else begin
                    chk("out_ctrl", g, 64'(oc[g]), 64'(q[0].c));
                    chk("out_data", g, od[g], q[0].d);
                    cand = q[0].d;
                end
                if (out_ready && q.size() != 0) begin
                    idle = q[0].d;
                    void'(q.pop_front());
                end
                if (sclr) begin
                    q.delete();
                    idle = (CD != 0) ? 64'd0 : cand;
                end
            end
        end

        // expected-response push: every accepted beat must come out later, in order
        always @(negedge clk) begin
            beat_t b;
            #1;
            if (!aclr && !sclr && in_valid && ir[g]) begin
                b.c = in_ctrl;
                b.d = in_data;
                q.push_back(b);
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] c, input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = {$urandom(), $urandom()};
        out_ready = ordy;
        sclr      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b0;
        cyc(0, 16'h0, 1, 0);

        for (int i = 1; i <= 5; i++) cyc(1, 16'(i), 1, 0);
        repeat (2) cyc(0, 16'h0, 1, 0);

        // back-pressure then drain
        cyc(1, 16'h000A, 0, 0);
        cyc(1, 16'h000B, 0, 0);
        repeat (2) cyc(0, 16'h0, 0, 0);
        repeat (3) cyc(0, 16'h0, 1, 0);

        // flush while full with a beat offered in the flush cycle
        cyc(1, 16'h000A, 0, 0);
        cyc(1, 16'h000B, 0, 0);
        cyc(1, 16'h000C, 0, 1);
        repeat (2) cyc(0, 16'h0, 0, 0);

        // pass-through, then drop out_ready mid-cycle
        repeat (4) cyc(1, 16'h1234, 1, 0);
        in_valid = 1'b1;
        #1;
        chk("comb_rdy_hi", 1, 64'(ir[1]), 64'd1);
        out_ready = 1'b0;
        #1;
        chk("comb_rdy_lo", 1, 64'(ir[1]), 64'd0);
        @(posedge clk);
        #1;
        repeat (3) cyc(0, 16'h0, 1, 0);

        // async reset while full
        cyc(1, 16'h00A1, 0, 0);
        cyc(1, 16'h00B2, 0, 0);
        in_valid = 1'b0;
        chk("pre_rst_occ", 0, 64'(occ[0]), 64'd2);
        #2;
        aclr = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 64'(ov[k]), 64'd0);
            chk("arst_ctrl", k, 64'(oc[k]), 64'd0);
            chk("arst_data", k, od[k], 64'd0);
            chk("arst_occ", k, 64'(occ[k]), 64'd0);
            chk("arst_rdy", k, 64'(ir[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        aclr = 1'b0;
        cyc(0, 16'h0, 0, 0);
        cyc(1, 16'h5A5A, 1, 0);
        repeat (2) cyc(0, 16'h0, 1, 0);

        for (int n = 0; n < 10000; n++)
            cyc(($urandom_range(0, 3) != 0), 16'($urandom()),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        repeat (4) cyc(0, 16'h0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that replaces the fixed-field stage registers between the decode, execute, memory and writeback stages.
- Carries an arbitrary control bundle and data bundle with a valid/ready handshake, so back-pressure and stalls no longer have to be done through an external enable.
- An optional 2-entry skid buffer makes in_ready a pure register output.
- A synchronous flush (sclr) turns the stage into a bubble, with all control bits zero.

Parameters:
- DATA_W, 64, width of the data bundle (operands, immediate, pc fields).
- CTRL_W, 16, width of the control bundle (wren, selects, alu op, ...). It is forced to zero whenever the stage holds no valid beat.
- SKID_EN, 1, 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.
- CLR_DATA, 0, 1 = flush and reset also zero out_data; 0 = out_data keeps its last value on flush.

Ports:
- clk, input, 1, rising-edge clock.
- aclr, input, 1, asynchronous reset, active-high.
- sclr, input, 1, synchronous flush, active-high.
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, stage can accept a beat this cycle.
- in_ctrl, input, CTRL_W, upstream control bundle.
- in_data, input, DATA_W, upstream data bundle.
- out_valid, output, 1, output beat present.
- out_ready, input, 1, downstream accepts the output beat.
- out_ctrl, output, CTRL_W, control bundle; all zero when out_valid=0.
- out_data, output, DATA_W, data bundle.
- occ, output, 2, number of beats held (0..2; 0..1 when SKID_EN=0).

Behaviour:
- Handshakes:
  - Accept happens when in_valid && in_ready.
  - Drain happens when out_valid && out_ready.
  - Beats leave in arrival order; none are duplicated or lost except by flush.
- Latency: an accepted beat appears on out_valid on the next clk edge (1 cycle) when the stage was empty or draining.
- Reset (aclr=1, asynchronous):
  - occ=0, out_valid=0, out_ctrl=0, out_data=0, skid entry cleared.
  - in_ready=0 while aclr is high.
  - First edge after release: in_ready=1.
- Once out_valid=1, out_ctrl and out_data are stable until drained or flushed, even if out_ready stays low.
- SKID_EN=1 uses a main entry (drives the outputs) and a skid entry. State is encoded by occ:
  - in_ready = (occ != 2), registered (no combinational path from out_ready).
  - EMPTY (occ=0):
    - accept -> main<=in, go to ONE.
  - ONE (occ=1):
    - accept && !drain -> skid<=in, go to FULL.
    - accept && drain -> main<=in, stay ONE.
    - !accept && drain -> go to EMPTY.
    - otherwise hold.
  - FULL (occ=2):
    - in_ready=0.
    - drain -> main<=skid, go to ONE.
    - otherwise hold.
- SKID_EN=0 uses the main entry only:
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous accept and drain reloads main in the same edge.
- Flush (sclr=1 at an edge) has priority over accept and drain:
  - Next state: occ=0, out_valid=0, out_ctrl=0, skid cleared.
  - out_data is zeroed if CLR_DATA=1, otherwise held.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - A drain in the flush cycle still counts downstream: out_valid was 1 during that cycle, so the consumer owns that beat.
- Bubble rule: out_ctrl == 0 whenever out_valid == 0, in every state, including after drain-to-empty. This keeps downstream write enables at zero so a bubble behaves as a NOP.
- Widths: bundles pass through bit-exact; no arithmetic.
- occ transitions by at most ±1 per edge, except flush, which goes to 0 from any value.
- aclr asserted mid-transfer: all state is lost immediately and outputs take their reset values without waiting for clk.

Test Plan:
- Reset, then stream. Release aclr, drive in_valid=1 with in_ctrl=0x0001..0x0005 on consecutive cycles, out_ready=1.
  -> out_valid rises 1 cycle after the first accept; out_ctrl shows 0x0001..0x0005 on consecutive cycles; occ stays 1; in_ready stays 1.
- Back-pressure, SKID_EN=1. Hold out_ready=0 and offer 0xA and 0xB.
  -> occ goes 1 then 2; in_ready=0 in the cycle after the second accept; out_ctrl holds 0xA.
  -> Raise out_ready: 0xA then 0xB drain; in_ready returns to 1 after the first drain.
- Flush while full. occ=2, assert sclr for one cycle with in_valid=1, in_ctrl=0xC.
  -> Next cycle: occ=0, out_valid=0, out_ctrl=0x0000; 0xC never appears; out_data is held (CLR_DATA=0) or 0 (CLR_DATA=1).
- SKID_EN=0 pass-through. out_valid=1, out_ready=1, in_valid=1.
  -> in_ready=1 in the same cycle; main reloads each edge; occ never exceeds 1.
  -> Drop out_ready: in_ready falls combinationally in the same cycle.
- Async reset mid-operation. occ=2; assert aclr between clock edges.
  -> out_valid, out_ctrl, out_data, occ and in_ready go to 0 before the next clk edge.
  -> After release, the first beat accepted is delivered intact.
- Bubble check. Randomised in_valid/out_ready/sclr for 10k cycles against a reference queue model.
  -> Output order matches; out_ctrl==0 on every cycle with out_valid==0.
